// File: rtl/winograd_post_transform_2d.sv
// winograd_post_transform_2d: streaming F(4,3) output transform Y = At*M*A, row pass on ingest, column pass on emit
module winograd_post_transform_2d #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [6*DATA_WIDTH-1:0] in_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*DATA_WIDTH-1:0] out_row,
    output logic                    out_last
);
    typedef enum logic {LOAD, EMIT} state_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
    state_t state, state_nxt;
    logic [2:0] row_cnt;
    logic [1:0] out_cnt;
    logic [5:0][DATA_WIDTH-1:0] m;
    logic [3:0][DATA_WIDTH-1:0] prow, yrow;
    logic [3:0][DATA_WIDTH-1:0] p [6];
    // One At row applied to six values; the same butterfly serves both passes.
    function automatic word_t at_row(input logic [1:0] i, input word_t v0, v1, v2, v3, v4, v5);
        word_t s12, d12, s34, d34;
        s12 = v1 + v2;
        d12 = v1 - v2;
        s34 = v3 + v4;
        d34 = v3 - v4;
        return i == 2'd0 ? v0 + s12 + s34 :
               i == 2'd1 ? d12 + (d34 << 1) :
               i == 2'd2 ? s12 + (s34 << 2) :
                           d12 + (d34 << 3) + v5;
    endfunction
    assign m       = in_row;
    assign out_row = yrow;
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            prow[j] = at_row(2'(j), m[0], m[1], m[2], m[3], m[4], m[5]);
            yrow[j] = at_row(out_cnt, p[0][j], p[1][j], p[2][j], p[3][j], p[4][j], p[5][j]);
        end
    end
    always_comb begin
        in_ready  = state == LOAD;
        out_valid = state == EMIT;
        out_last  = out_valid && out_cnt == 2'd3;
        state_nxt = (in_ready && in_valid && row_cnt == 3'd5) ? EMIT :
                    (out_last && out_ready)                   ? LOAD : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= LOAD;
            row_cnt <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (in_ready && in_valid) begin
                p[row_cnt] <= prow;
                row_cnt    <= row_cnt == 3'd5 ? 3'd0 : row_cnt + 3'd1;
            end
            if (out_valid && out_ready)
                out_cnt <= out_cnt + 2'd1;
        end
    end
endmodule

// File: doc/winograd_post_transform_2d.md
# winograd_post_transform_2d

Streaming Winograd F(4,3) output transform: consumes one 6×6 element-wise-product tile M row by row and produces the 4×4 spatial output tile Y = Aᵀ·M·A row by row. It sits after the element-wise multiply stage, at the opposite end of the datapath from the 6×6 input (Bᵀ·d·B) pre-transform. Row transform is applied on ingest into a 6×4 intermediate buffer. Column transform is applied on emission.

## Interface
- DATA_WIDTH, 32, element width; two's-complement, all arithmetic modulo 2^DATA_WIDTH
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset (sampled on rising edge of clk)
- in_valid  in  1  in_row carries a valid M row
- in_ready  out  1  block can accept a row this cycle
- in_row  in  6×DATA_WIDTH  M[r][0..5], element 0 in lowest slice
- out_valid  out  1  out_row carries a valid Y row
- out_ready  in  1  downstream accepts out_row this cycle
- out_row  out  4×DATA_WIDTH  Y[i][0..3], element 0 in lowest slice
- out_last  out  1  high with out_valid on Y row 3

## Operation
- Aᵀ rows: a0=[1,1,1,1,1,0], a1=[0,1,-1,2,-2,0], a2=[0,1,1,4,4,0], a3=[0,1,-1,8,-8,1].
- Row pass, for accepted row r with elements m0..m5: P[r][0]=m0+m1+m2+m3+m4; P[r][1]=m1−m2+2m3−2m4; P[r][2]=m1+m2+4m3+4m4; P[r][3]=m1−m2+8m3−8m4+m5.
- Column pass, output row i: Y[i][j]=Σ_r a_i[r]·P[r][j].
- Multiplies by 2/4/8 are shifts. No hardware multipliers. Results are truncated to DATA_WIDTH with no saturation.
- FSM states:
  - LOAD: in_ready=1. row_cnt counts 0..5. Each handshake (in_valid&in_ready) writes P[row_cnt]. The handshake with row_cnt=5 moves to EMIT with out_cnt=0.
  - EMIT: in_ready=0, out_valid=1. out_row = column pass for row out_cnt, combinational from the P buffer. Each handshake (out_valid&out_ready) increments out_cnt. The handshake with out_cnt=3 returns to LOAD with row_cnt=0.
- Tile framing is implicit by count. There is no input last signal.
- P buffer is not cleared between tiles. Every entry is overwritten before it is read.

## Timing
- Reset values: state=LOAD, row_cnt=0, out_cnt=0, in_ready=1, out_valid=0, out_last=0. out_row is don't-care while out_valid=0.
- Reset asserted mid-tile, in either state, discards the partial tile. The next cycle is the reset state.
- Input throughput is 1 row/cycle while in LOAD. in_valid low stalls row_cnt.
- Latency: the handshake on row 5 at edge N gives out_valid=1 with Y row 0 in the cycle after N.
- Output: one row per cycle when out_ready is held high. Best case is 6 input cycles + 4 output cycles = 10 cycles per tile.
- Backpressure: while out_valid=1 and out_ready=0, out_row, out_last and out_cnt are held stable.
- in_ready is deasserted for the whole of EMIT. in_valid during EMIT is ignored and is not counted.
- in_ready rises in the cycle after the row-3 output handshake, so a new tile's row 0 can be accepted then.
- out_last = (state==EMIT) && (out_cnt==3).

## Test plan
- Reset, then stream 6 rows of all 1s with out_ready=1. Required response:
  - Y rows [25,0,50,5], [0,0,0,0], [50,0,100,10], [5,0,10,1].
  - out_last on the 4th row only.
  - First out_valid one cycle after the 6th input handshake.
- Impulse M[0][0]=1, all else 0 → Y[0][0]=1, all other outputs 0. Impulse M[5][5]=1 → only Y[3][3]=1.
- Wrap: M[3][3]=0x10000000, all else 0 → Y[0][0]=0x10000000, Y[0][3]=0x80000000, Y[2][2]=0, Y[3][3]=0.
- Backpressure and stall:
  - Random in_valid gaps and random out_ready → results identical to the all-1s case.
  - out_row and out_last are stable while stalled.
  - in_ready=0 throughout EMIT, and in_valid pulses during EMIT do not alter the next tile.
- Back-to-back tiles: tile A all 1s, then tile B all 2s → B outputs are exactly 2× A's. No leftover P data appears.
- Assert rst_n=0 after 3 input rows, then send a full all-1s tile → correct all-1s output. out_valid=0 in the cycle after reset.
